// File: rtl/tiny_cpu_pkg.sv
// Shared opcode and FSM state encodings for the tiny_cpu_gen2 core.
package tiny_cpu_pkg;

   // Instruction opcodes (upper four bits of the instruction word)
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_CLR = 4'd1;
   localparam logic [3:0] OP_LDI = 4'd2;
   localparam logic [3:0] OP_MOV = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;
   localparam logic [3:0] OP_OR  = 4'd7;
   localparam logic [3:0] OP_XOR = 4'd8;
   localparam logic [3:0] OP_NOT = 4'd9;
   localparam logic [3:0] OP_SHL = 4'd10;
   localparam logic [3:0] OP_SHR = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;
   localparam logic [3:0] OP_OUT = 4'd13;
   localparam logic [3:0] OP_LDR = 4'd14;
   localparam logic [3:0] OP_RSV = 4'd15;

   // Control FSM: IDLE accepts instructions, MUL waits for the multiplier
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/tiny_cpu_gen2_if.sv
// Instruction/result/debug bundle between a driver (master) and the core (slave).
interface tiny_cpu_gen2_if #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) ();
   localparam int RW = $clog2(NREGS);
   localparam int IW = 4 + 2*RW + WIDTH;

   logic [IW-1:0]    i_in;
   logic             i_in_valid;
   logic             o_in_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_result_valid;
   logic             o_zero;
   logic             o_carry;
   logic             o_illegal;
   logic [RW-1:0]    i_dbg_sel;
   logic [WIDTH-1:0] o_dbg_data;

   modport master (
      output i_in, i_in_valid, i_dbg_sel,
      input  o_in_ready, o_result, o_result_valid, o_zero, o_carry, o_illegal, o_dbg_data
   );

   modport slave (
      input  i_in, i_in_valid, i_dbg_sel,
      output o_in_ready, o_result, o_result_valid, o_zero, o_carry, o_illegal, o_dbg_data
   );
endinterface

// File: rtl/shift_add_mul.sv
// Multi-cycle shift-add multiplier. Operands are captured on i_start; o_done is
// high during the cycle before the WIDTH-th edge after start, with o_product
// already including the final partial product so the caller can write it on
// that edge.
module shift_add_mul #(
   parameter int WIDTH = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product
);
   localparam int CW = $clog2(WIDTH);

   logic               r_busy;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;

   logic [2*WIDTH-1:0] w_addend;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_addend   = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next = r_acc + w_addend;
   assign o_done     = r_busy && (r_cnt == CW'(WIDTH - 1));
   assign o_product  = w_acc_next;

   // Capture operands on start, then consume one multiplier bit per edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_acc    <= '0;
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
         if (o_done) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/tiny_cpu_gen2.sv
// Tiny accumulator-style CPU: decode, register file and flags live here; the
// multiply is delegated to shift_add_mul while the FSM holds off new work.
module tiny_cpu_gen2
   import tiny_cpu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   tiny_cpu_gen2_if.slave  bus
);
   localparam int RW = $clog2(NREGS);
   localparam int IW = 4 + 2*RW + WIDTH;

   // Architectural state
   logic [0:0]       r_state;
   logic [RW-1:0]    r_mul_rd;
   logic [WIDTH-1:0] r_result;
   logic             r_result_valid;
   logic             r_illegal;
   logic             r_zero;
   logic             r_carry;

   // Instruction fields and operands
   logic [3:0]       w_op;
   logic [RW-1:0]    w_rd;
   logic [RW-1:0]    w_rs;
   logic [WIDTH-1:0] w_imm;
   logic [WIDTH-1:0] w_regs [NREGS];
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;

   // Decode outputs
   logic             w_we_any;
   logic [RW-1:0]    w_waddr;
   logic [WIDTH-1:0] w_wdata;
   logic             w_zero_val;
   logic             w_upd_zero;
   logic             w_upd_carry;
   logic             w_carry_val;
   logic             w_clr;
   logic             w_out;
   logic             w_ill;
   logic             w_mul_start;

   // Multiplier handshake
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_product;

   assign w_op   = bus.i_in[IW-1 -: 4];
   assign w_rd   = bus.i_in[WIDTH+2*RW-1 -: RW];
   assign w_rs   = bus.i_in[WIDTH+RW-1 -: RW];
   assign w_imm  = bus.i_in[WIDTH-1:0];
   assign w_a    = w_regs[w_rd];
   assign w_b    = w_regs[w_rs];
   assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
   // The top bit of the widened difference is the unsigned borrow (rd < rs)
   assign w_diff = {1'b0, w_a} - {1'b0, w_b};
   assign w_zero_val = (w_wdata == '0);

   shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (w_mul_start),
      .i_a       (w_a),
      .i_b       (w_b),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   // Decode: single-cycle ops act on the accepting edge; a finished multiply writes back
   always_comb begin
      w_we_any    = 1'b0;
      w_waddr     = w_rd;
      w_wdata     = '0;
      w_upd_zero  = 1'b0;
      w_upd_carry = 1'b0;
      w_carry_val = 1'b0;
      w_clr       = 1'b0;
      w_out       = 1'b0;
      w_ill       = 1'b0;
      w_mul_start = 1'b0;
      if (r_state == ST_MUL) begin
         if (w_mul_done) begin
            w_we_any    = 1'b1;
            w_waddr     = r_mul_rd;
            w_wdata     = w_product[WIDTH-1:0];
            w_upd_zero  = 1'b1;
            w_upd_carry = 1'b1;
            w_carry_val = |w_product[2*WIDTH-1:WIDTH];
         end
      end else if (bus.i_in_valid) begin
         case (w_op)
            OP_NOP: ;
            OP_CLR: w_clr = 1'b1;
            OP_LDI: begin w_we_any = 1'b1; w_wdata = w_imm; end
            OP_MOV: begin w_we_any = 1'b1; w_wdata = w_b; end
            OP_ADD: begin
               w_we_any = 1'b1; w_wdata = w_sum[WIDTH-1:0]; w_upd_zero = 1'b1;
               w_upd_carry = 1'b1; w_carry_val = w_sum[WIDTH];
            end
            OP_SUB: begin
               w_we_any = 1'b1; w_wdata = w_diff[WIDTH-1:0]; w_upd_zero = 1'b1;
               w_upd_carry = 1'b1; w_carry_val = w_diff[WIDTH];
            end
            OP_AND: begin w_we_any = 1'b1; w_wdata = w_a & w_b; w_upd_zero = 1'b1; end
            OP_OR:  begin w_we_any = 1'b1; w_wdata = w_a | w_b; w_upd_zero = 1'b1; end
            OP_XOR: begin w_we_any = 1'b1; w_wdata = w_a ^ w_b; w_upd_zero = 1'b1; end
            OP_NOT: begin w_we_any = 1'b1; w_wdata = ~w_b; w_upd_zero = 1'b1; end
            OP_SHL: begin
               w_we_any = 1'b1; w_wdata = {w_a[WIDTH-2:0], 1'b0}; w_upd_zero = 1'b1;
               w_upd_carry = 1'b1; w_carry_val = w_a[WIDTH-1];
            end
            OP_SHR: begin
               w_we_any = 1'b1; w_wdata = {1'b0, w_a[WIDTH-1:1]}; w_upd_zero = 1'b1;
               w_upd_carry = 1'b1; w_carry_val = w_a[0];
            end
            OP_MUL: w_mul_start = 1'b1;
            OP_OUT: w_out = 1'b1;
            OP_LDR: begin w_we_any = 1'b1; w_wdata = r_result; end
            default: w_ill = 1'b1;
         endcase
      end
   end

   // Register file: one flop bank per register so CLR and reset clear all at once
   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         logic [WIDTH-1:0] r_q;
         // Hold, clear, or load this register from the shared write port
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_q <= '0;
            end else if (w_clr) begin
               r_q <= '0;
            end else if (w_we_any && (w_waddr == RW'(gi))) begin
               r_q <= w_wdata;
            end
         end
         assign w_regs[gi] = r_q;
      end
   endgenerate

   // FSM, result register, flags and one-cycle status pulses
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_mul_rd       <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_illegal      <= 1'b0;
         r_zero         <= 1'b0;
         r_carry        <= 1'b0;
      end else begin
         r_result_valid <= w_out;
         r_illegal      <= w_ill;
         if (w_clr) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
         end else begin
            if (w_out)       r_result <= w_b;
            if (w_upd_zero)  r_zero   <= w_zero_val;
            if (w_upd_carry) r_carry  <= w_carry_val;
         end
         if (w_mul_start) begin
            r_state  <= ST_MUL;
            r_mul_rd <= w_rd;
         end else if (w_mul_done) begin
            r_state  <= ST_IDLE;
         end
      end
   end

   assign bus.o_in_ready     = (r_state == ST_IDLE);
   assign bus.o_result       = r_result;
   assign bus.o_result_valid = r_result_valid;
   assign bus.o_zero         = r_zero;
   assign bus.o_carry        = r_carry;
   assign bus.o_illegal      = r_illegal;
   assign bus.o_dbg_data     = w_regs[bus.i_dbg_sel];
endmodule

// File: tb/tb_tiny_cpu_gen2.sv
// Directed-vector bench for tiny_cpu_gen2 (WIDTH=8, NREGS=4).
module tb_tiny_cpu_gen2;
   import tiny_cpu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   tiny_cpu_gen2_if #(.WIDTH(8), .NREGS(4)) bus ();

   tiny_cpu_gen2 #(.WIDTH(8), .NREGS(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Offer one instruction while the core is idle; returns 1 time unit after the accepting edge
   task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] imm);
      @(negedge clk);
      bus.i_in       = enc(op, rd, rs, imm);
      bus.i_in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_in_valid = 1'b0;
      $display("issue op=%0d rd=%0d rs=%0d imm=%0d", op, rd, rs, imm);
   endtask

   task automatic chk_reg(input string tag, input int idx, input logic [7:0] exp);
      bus.i_dbg_sel = 2'(idx);
      #1;
      chk(tag, 32'(bus.o_dbg_data), 32'(exp));
   endtask

   task automatic chk_flags(input string tag, input logic z, input logic c);
      chk({tag, ".zero"}, 32'(bus.o_zero), 32'(z));
      chk({tag, ".carry"}, 32'(bus.o_carry), 32'(c));
   endtask

   // Issue MUL and count the sampled cycles during which In_ready stays low
   task automatic run_mul(input logic [1:0] rd, input logic [1:0] rs, output int low);
      issue(OP_MUL, rd, rs, 8'd0);
      low = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.o_in_ready) break;
         low++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int low;
      int waits;
      bit accepted;
      n_checks = 0;
      n_errors = 0;
      bus.i_in = '0;
      bus.i_in_valid = 1'b0;
      bus.i_dbg_sel = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #3;
      chk("rst.ready", 32'(bus.o_in_ready), 32'd1);
      chk("rst.result", 32'(bus.o_result), 32'd0);
      chk_flags("rst", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) chk_reg($sformatf("rst.r%0d", i), i, 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Add with carry-out, then subtract to zero
      issue(OP_LDI, 2'd0, 2'd0, 8'd200);
      issue(OP_LDI, 2'd1, 2'd0, 8'd100);
      issue(OP_ADD, 2'd0, 2'd1, 8'd0);
      chk_reg("add.r0", 0, 8'd44);
      chk_flags("add", 1'b0, 1'b1);
      issue(OP_SUB, 2'd1, 2'd1, 8'd0);
      chk_reg("sub.r1", 1, 8'd0);
      chk_flags("sub", 1'b1, 1'b0);

      // Debug port shows the old value during the write cycle
      @(negedge clk);
      bus.i_in = enc(OP_LDI, 2'd0, 2'd0, 8'd99);
      bus.i_in_valid = 1'b1;
      bus.i_dbg_sel = 2'd0;
      #1;
      chk("dbg.pre_edge", 32'(bus.o_dbg_data), 32'd44);
      @(posedge clk);
      #1;
      bus.i_in_valid = 1'b0;
      chk_reg("dbg.post_edge", 0, 8'd99);

      // Multi-cycle multiply without overflow
      issue(OP_LDI, 2'd2, 2'd0, 8'd13);
      issue(OP_LDI, 2'd3, 2'd0, 8'd11);
      run_mul(2'd2, 2'd3, low);
      chk("mul1.busy_cycles", 32'(low), 32'd8);
      chk_reg("mul1.r2", 2, 8'd143);
      chk_flags("mul1", 1'b0, 1'b0);

      // Output register and reload
      issue(OP_OUT, 2'd0, 2'd2, 8'd0);
      chk("out.result", 32'(bus.o_result), 32'd143);
      chk("out.valid", 32'(bus.o_result_valid), 32'd1);
      @(posedge clk);
      #1;
      chk("out.valid_drop", 32'(bus.o_result_valid), 32'd0);
      chk("out.result_hold", 32'(bus.o_result), 32'd143);
      issue(OP_LDR, 2'd3, 2'd0, 8'd0);
      chk_reg("ldr.r3", 3, 8'd143);

      // Multiply with overflow into the upper half
      issue(OP_LDI, 2'd2, 2'd0, 8'd20);
      issue(OP_LDI, 2'd3, 2'd0, 8'd20);
      run_mul(2'd2, 2'd3, low);
      chk("mul2.busy_cycles", 32'(low), 32'd8);
      chk_reg("mul2.r2", 2, 8'd144);
      chk_flags("mul2", 1'b0, 1'b1);

      // Squaring with rd==rs: 16*16 = 256 wraps to zero
      issue(OP_LDI, 2'd1, 2'd0, 8'd16);
      run_mul(2'd1, 2'd1, low);
      chk_reg("sq.r1", 1, 8'd0);
      chk_flags("sq", 1'b1, 1'b1);

      // ADD offered while the multiplier is busy, valid held until accepted
      issue(OP_LDI, 2'd0, 2'd0, 8'd3);
      issue(OP_LDI, 2'd1, 2'd0, 8'd4);
      issue(OP_MUL, 2'd0, 2'd1, 8'd0);
      @(negedge clk);
      bus.i_in = enc(OP_ADD, 2'd1, 2'd1, 8'd0);
      bus.i_in_valid = 1'b1;
      waits = 0;
      accepted = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.o_in_ready) begin
            @(posedge clk);
            #1;
            bus.i_in_valid = 1'b0;
            accepted = 1'b1;
            break;
         end
         waits++;
         @(negedge clk);
      end
      bus.i_in_valid = 1'b0;
      chk("hold.accepted", 32'(accepted), 32'd1);
      chk("hold.wait_cycles", 32'(waits), 32'd8);
      chk_reg("hold.r0", 0, 8'd12);
      chk_reg("hold.r1", 1, 8'd8);
      chk_flags("hold", 1'b0, 1'b0);

      // Reserved opcode changes nothing but pulses Illegal
      issue(OP_LDI, 2'd3, 2'd0, 8'd200);
      issue(OP_SHL, 2'd3, 2'd0, 8'd0);
      chk_reg("shl.r3", 3, 8'd144);
      chk_flags("shl", 1'b0, 1'b1);
      issue(OP_RSV, 2'd0, 2'd1, 8'd55);
      chk("ill.pulse", 32'(bus.o_illegal), 32'd1);
      @(posedge clk);
      #1;
      chk("ill.drop", 32'(bus.o_illegal), 32'd0);
      chk_reg("ill.r0", 0, 8'd12);
      chk_reg("ill.r1", 1, 8'd8);
      chk_reg("ill.r2", 2, 8'd144);
      chk_reg("ill.r3", 3, 8'd144);
      chk("ill.result", 32'(bus.o_result), 32'd143);
      chk_flags("ill", 1'b0, 1'b1);

      issue(OP_CLR, 2'd0, 2'd0, 8'd0);
      for (int i = 0; i < 4; i++) chk_reg($sformatf("clr.r%0d", i), i, 8'd0);
      chk("clr.result", 32'(bus.o_result), 32'd0);
      chk_flags("clr", 1'b0, 1'b0);

      // Logic and shift ops; logic ops leave Carry alone
      issue(OP_LDI, 2'd0, 2'd0, 8'd255);
      issue(OP_SHL, 2'd0, 2'd0, 8'd0);
      chk_reg("shl2.r0", 0, 8'd254);
      issue(OP_LDI, 2'd1, 2'd0, 8'd240);
      issue(OP_LDI, 2'd2, 2'd0, 8'd60);
      issue(OP_AND, 2'd1, 2'd2, 8'd0);
      chk_reg("and.r1", 1, 8'd48);
      chk_flags("and", 1'b0, 1'b1);
      issue(OP_OR, 2'd1, 2'd2, 8'd0);
      chk_reg("or.r1", 1, 8'd60);
      issue(OP_XOR, 2'd1, 2'd2, 8'd0);
      chk_reg("xor.r1", 1, 8'd0);
      chk_flags("xor", 1'b1, 1'b1);
      issue(OP_NOT, 2'd3, 2'd2, 8'd0);
      chk_reg("not.r3", 3, 8'd195);
      issue(OP_SHR, 2'd0, 2'd0, 8'd0);
      chk_reg("shr.r0", 0, 8'd127);
      chk_flags("shr", 1'b0, 1'b0);
      issue(OP_MOV, 2'd3, 2'd0, 8'd0);
      chk_reg("mov.r3", 3, 8'd127);

      // Asynchronous reset in the middle of a multiply
      issue(OP_OUT, 2'd0, 2'd3, 8'd0);
      issue(OP_LDI, 2'd1, 2'd0, 8'd255);
      issue(OP_ADD, 2'd1, 2'd1, 8'd0);
      issue(OP_LDI, 2'd2, 2'd0, 8'd5);
      issue(OP_MUL, 2'd2, 2'd3, 8'd0);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #3;
      chk("pre_rst.ready", 32'(bus.o_in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst.ready", 32'(bus.o_in_ready), 32'd1);
      chk("arst.result", 32'(bus.o_result), 32'd0);
      chk_flags("arst", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) chk_reg($sformatf("arst.r%0d", i), i, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) @(posedge clk);
      #1;
      chk_reg("abort.r2", 2, 8'd0);
      chk("abort.ready", 32'(bus.o_in_ready), 32'd1);
      issue(OP_LDI, 2'd2, 2'd0, 8'd77);
      chk_reg("resume.r2", 2, 8'd77);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/tiny_cpu_gen2.md
TINY_CPU_GEN2 -- requirements
Module: tiny_cpu_gen2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data/register width (>=4).
REQ-002 SHALL have parameter NREGS, default 4, giving the register-file depth (power of 2, >=2); RW = log2(NREGS).
REQ-003 SHALL use instruction width IW = 4+2*RW+WIDTH, laid out as In = {op[3:0], rd[RW-1:0], rs[RW-1:0], imm[WIDTH-1:0]}.
REQ-004 Clk  in  1  single clock; all state changes on the rising edge.
REQ-005 Rst_n  in  1  reset, asynchronous and active-low.
REQ-006 In  in  IW  instruction word.
REQ-007 In_valid  in  1  instruction offered.
REQ-008 In_ready  out  1  instruction accepted when In_valid and In_ready are both high at an edge.
REQ-009 Result  out  WIDTH  output register.
REQ-010 Result_valid  out  1  one-cycle pulse when Result is written.
REQ-011 Zero, Carry  out  1 each  status flags.
REQ-012 Illegal  out  1  one-cycle pulse on reserved opcode.
REQ-013 Dbg_sel  in  RW  debug read select; Dbg_data  out  WIDTH  = reg[Dbg_sel], combinational.

Function
REQ-014 SHALL decode ops: 0 NOP; 1 CLR (all regs, Result, flags <= 0); 2 LDI rd<=imm; 3 MOV rd<=rs; 4 ADD rd<=rd+rs; 5 SUB rd<=rd-rs; 6 AND; 7 OR; 8 XOR; 9 NOT rd<=~rs; 10 SHL rd<=rd<<1; 11 SHR rd<=rd>>1 (logical); 12 MUL rd<=low WIDTH bits of rd*rs; 13 OUT Result<=rs; 14 LDR rd<=Result; 15 reserved.
REQ-015 SHALL use a two-state FSM: IDLE (In_ready=1) and MUL (In_ready=0).
REQ-016 In IDLE, all ops except MUL SHALL complete at the accepting edge; the FSM stays in IDLE.
REQ-017 Accepting MUL SHALL latch both operands, enter MUL, run a shift-add over WIDTH cycles, write rd and flags at the WIDTH-th edge after acceptance, and return to IDLE; In_ready is low for exactly WIDTH cycles.
REQ-018 MUL with rd==rs SHALL square the operand value latched at acceptance.
REQ-019 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-020 Carry SHALL update as follows: ADD carry-out; SUB borrow (1 when rd<rs, unsigned); SHL shifted-out MSB; SHR shifted-out LSB; MUL 1 when the upper WIDTH product bits are nonzero.
REQ-021 All other ops SHALL leave Carry unchanged.
REQ-022 Zero SHALL equal (written value==0) on ops 4-12; all other ops SHALL leave Zero unchanged.
REQ-023 Result_valid SHALL pulse in the cycle after an accepted OUT; Result SHALL hold its value otherwise.
REQ-024 Op 15 SHALL change no state and pulse Illegal in the following cycle.
REQ-025 In_valid while In_ready is low SHALL be ignored, and no instruction SHALL be lost or duplicated.
REQ-026 Dbg_data SHALL show the pre-edge register value in the cycle of a write.

Reset
REQ-027 Rst_n low SHALL immediately force all registers, Result, Zero, Carry, Result_valid and Illegal to 0, set FSM to IDLE and In_ready to 1.
REQ-028 Reset during MUL SHALL abort the multiply with no register write.
REQ-029 Normal operation SHALL resume at the first rising edge after Rst_n deasserts.

Structure
REQ-030 Opcode constants and FSM state encodings SHALL live in shared package tiny_cpu_pkg.
REQ-031 The multi-cycle multiplier SHALL be a sub-module shift_add_mul (start, operands, done, 2*WIDTH product); decode, regfile and flags SHALL stay in the top module.

Verification (WIDTH=8, NREGS=4)
REQ-032 Assert Rst_n low mid-MUL -> Dbg_data=0 for all regs, Result=0, flags 0, In_ready=1 without waiting for a clock edge.
REQ-033 LDI r0,200; LDI r1,100; ADD r0,r1 -> r0=44, Carry=1, Zero=0; then SUB r1,r1 -> r1=0, Zero=1, Carry=0.
REQ-034 LDI r2,13; LDI r3,11; MUL r2,r3 -> In_ready low 8 cycles, r2=143, Carry=0; then r2=r3=20, MUL -> r2=144, Carry=1.
REQ-035 Offer ADD while MUL is busy, holding In_valid -> ADD accepted only after In_ready rises, executed exactly once.
REQ-036 OUT r2 (r2=143) -> Result=143, Result_valid high one cycle; then LDR r3 -> r3=143.
REQ-037 Op 15 -> Illegal pulse one cycle, registers, flags and Result unchanged; CLR -> all zero.
